// File: rtl/clock_pkg.sv
// Shared BCD digit type and digit limits for the clock timekeeping and display path.
package clock_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t SEC_MAX_TENS       = 4'd5;
  localparam bcd_t MIN_MAX_TENS       = 4'd5;
  localparam bcd_t HR_MAX_TENS        = 4'd2;
  localparam bcd_t HR_MAX_ONES_AT_TOP = 4'd3;
  localparam bcd_t BCD_MAX            = 4'd9;

  typedef struct packed {
    bcd_t hr_tens;
    bcd_t hr_ones;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } time_bcd_t;

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps to 00 after {WRAP_TENS,WRAP_ONES}.
// carry_out_c flags the increment that causes the wrap.
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter bcd_t WRAP_TENS = 4'd5,
  parameter bcd_t WRAP_ONES = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t ones,
  output bcd_t tens,
  output logic carry_out_c
);

  bcd_t ones_nxt;
  bcd_t tens_nxt;
  logic at_wrap;

  assign at_wrap     = (tens == WRAP_TENS) && (ones == WRAP_ONES);
  assign carry_out_c = inc && !clr && at_wrap;

  // Next digit pair; out-of-range digits fall back to 0 on their next update.
  always_comb begin
    ones_nxt = ones;
    tens_nxt = tens;
    if (clr) begin
      ones_nxt = '0;
      tens_nxt = '0;
    end else if (inc) begin
      if (at_wrap) begin
        ones_nxt = '0;
        tens_nxt = '0;
      end else if (ones >= BCD_MAX) begin
        ones_nxt = '0;
        tens_nxt = (tens >= WRAP_TENS) ? '0 : tens + 4'd1;
      end else begin
        ones_nxt = ones + 4'd1;
        tens_nxt = (tens > WRAP_TENS) ? '0 : tens;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= '0;
      tens <= '0;
    end else begin
      ones <= ones_nxt;
      tens <= tens_nxt;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD timekeeper with 1 Hz prescaler and button-driven set mode.
// All outputs come straight from flops.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic set_mode,
  input  logic inc_min,
  input  logic inc_hr,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output bcd_t hr_ones,
  output bcd_t hr_tens,
  output logic tick_1hz,
  output logic day_roll
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick_int;
  logic             sec_carry;
  logic             min_carry;
  logic             hr_carry;
  logic             min_inc;
  logic             hr_inc;

  assign tick_int = en && !set_mode && (cnt == CNT_TOP);

  // Set mode parks the prescaler so the first tick after exit is a full period away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (set_mode) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_int ? '0 : cnt + CNT_W'(1);
    end
  end

  // In set mode the buttons drive minutes and hours directly, with no carry between them.
  assign min_inc = set_mode ? inc_min : sec_carry;
  assign hr_inc  = set_mode ? inc_hr  : min_carry;

  bcd_pair_counter #(
    .WRAP_TENS(SEC_MAX_TENS),
    .WRAP_ONES(BCD_MAX)
  ) u_sec (
    .clk        (clk),
    .rst        (reset),
    .clr        (set_mode),
    .inc        (tick_int),
    .ones       (sec_ones),
    .tens       (sec_tens),
    .carry_out_c(sec_carry)
  );

  bcd_pair_counter #(
    .WRAP_TENS(MIN_MAX_TENS),
    .WRAP_ONES(BCD_MAX)
  ) u_min (
    .clk        (clk),
    .rst        (reset),
    .clr        (1'b0),
    .inc        (min_inc),
    .ones       (min_ones),
    .tens       (min_tens),
    .carry_out_c(min_carry)
  );

  bcd_pair_counter #(
    .WRAP_TENS(HR_MAX_TENS),
    .WRAP_ONES(HR_MAX_ONES_AT_TOP)
  ) u_hr (
    .clk        (clk),
    .rst        (reset),
    .clr        (1'b0),
    .inc        (hr_inc),
    .ones       (hr_ones),
    .tens       (hr_tens),
    .carry_out_c(hr_carry)
  );

  // Pulses land in the same cycle as the digits they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_1hz <= 1'b0;
      day_roll <= 1'b0;
    end else begin
      tick_1hz <= tick_int;
      day_roll <= hr_carry && !set_mode;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: a seconds-of-day model predicts each cycle.
module tb_bcd_time_counter;
  import clock_pkg::*;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CNT_W    = 3;

  logic clk = 1'b0;
  logic reset, en, set_mode, inc_min, inc_hr;
  bcd_t sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic tick_1hz, day_roll;

  bcd_time_counter #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .hr_ones(hr_ones), .hr_tens(hr_tens),
    .tick_1hz(tick_1hz), .day_roll(day_roll)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] digits;
    logic        tick;
    logic        roll;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  int m_t;    // seconds of day
  int m_p;    // prescaler
  logic m_tick, m_roll;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    logic [23:0] r;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  function automatic logic [23:0] dut_digits();
    return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Model of one rising edge given the inputs presented before it.
  task automatic model_edge(input logic e, input logic sm, input logic im, input logic ih);
    int h, m;
    m_tick = 1'b0;
    m_roll = 1'b0;
    if (sm) begin
      m_p = 0;
      h = m_t / 3600;
      m = (m_t / 60) % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      m_t = h * 3600 + m * 60;
    end else if (e) begin
      if (m_p == TICK_DIV - 1) begin
        m_p = 0;
        m_t = (m_t + 1) % 86400;
        m_tick = 1'b1;
        m_roll = (m_t == 0);
      end else begin
        m_p++;
      end
    end
  endtask

  task automatic step(input logic e, input logic sm, input logic im, input logic ih);
    exp_t x, o;
    en = e; set_mode = sm; inc_min = im; inc_hr = ih;
    @(posedge clk);
    model_edge(e, sm, im, ih);
    x.digits = to_bcd(m_t);
    x.tick   = m_tick;
    x.roll   = m_roll;
    q.push_back(x);
    #1;
    if (q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      o = q.pop_front();
      check("digits", 32'(dut_digits()), 32'(o.digits));
      check("tick_1hz", 32'(tick_1hz), 32'(o.tick));
      check("day_roll", 32'(day_roll), 32'(o.roll));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    m_t = 0; m_p = 0;
    q.delete();
    #1;
    check("reset_digits", 32'(dut_digits()), 32'd0);
    check("reset_pulses", 32'({tick_1hz, day_roll}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic sm_r;

  initial begin
    reset = 1'b0; en = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    m_t = 0; m_p = 0;
    #2;
    do_reset();

    // first tick after release
    run(4);
    check("first_tick_sec", 32'(dut_digits()), 32'h000001);
    run(2);

    // asynchronous reset mid-count, sampled away from any edge
    #2;
    do_reset();
    run(4);

    // preload 00:59:00 with en low, then run to the hour carry
    for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("preload_0059", 32'(dut_digits()), 32'h005900);
    run(59 * TICK_DIV);
    check("at_005959", 32'(dut_digits()), 32'h005959);
    run(TICK_DIV);
    check("at_010000", 32'(dut_digits()), 32'h010000);

    // preload 23:59:00 and run to midnight
    for (int i = 0; i < 59; i++) step(1'b1, 1'b1, 1'b1, (i < 22) ? 1'b1 : 1'b0);
    check("preload_2359", 32'(dut_digits()), 32'h235900);
    run(60 * TICK_DIV);
    check("midnight_roll", 32'({day_roll, tick_1hz}), 32'b11);
    run(1);
    check("roll_one_cycle", 32'({day_roll, tick_1hz}), 32'b00);

    // reach 12:34:27 in run mode
    for (int i = 0; i < 34; i++) step(1'b1, 1'b1, 1'b1, (i < 12) ? 1'b1 : 1'b0);
    run(27 * TICK_DIV + 1);
    check("at_123427", 32'(dut_digits()), 32'h123427);

    // set mode: seconds clear, minute and hour wraps, dual increment
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("set_clears_sec", 32'(dut_digits()), 32'h123400);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("min_wrap_no_carry", 32'(dut_digits()), 32'h120000);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("hr_wrap", 32'(dut_digits()), 32'h000000);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, (i < 5) ? 1'b1 : 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("dual_inc", 32'(dut_digits()), 32'h060900);

    // exit, freeze with en low at prescaler 2, resume
    run(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    run(2);
    check("resume_tick", 32'(tick_1hz), 32'd1);

    // inc pulses outside set mode are ignored
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

    // random mix of modes, enables and buttons
    sm_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) sm_r = ~sm_r;
      step(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, sm_r,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
